// File: rtl/shift_unit_if.sv
// Request/response bundle for shift_unit: operands and start go in,
// busy/done status and the registered result come back.
interface shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;

  modport master (
    output start, mode, shamt, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, mode, shamt, data_in,
    output busy, done, data_out
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shifter: one 1-bit step per clock (SLL/SRL/SRA/ROL), then the
// result is published on data_out with a one-cycle done pulse.
module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset_n,
  shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] w,
                                             input logic [1:0]       op);
    logic [WIDTH-1:0] r;
    r = w;
    case (op)
      OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROL:  r = {w[WIDTH-2:0], w[WIDTH-1]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dout_d  = dout_q;
    case (state_q)
      // DONE accepts like IDLE so a held start chains without a gap.
      IDLE, DONE: begin
        if (bus.start) begin
          op_d    = bus.mode;
          cnt_d   = bus.shamt;
          work_d  = bus.data_in;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          work_d = step1(work_q, op_q);
          cnt_d  = cnt_q - SHAMT_W'(1);
        end else begin
          dout_d  = work_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.data_out = dout_q;

endmodule
